// File: rtl/real_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : real_sub_pipe
// Description : Two-stage valid/ready pipelined multi-channel two's-complement
//               subtractor (diff = a - b per channel) with per-channel
//               overflow flags and a saturating overflow-event counter.
//               Optional feature macro: REAL_SUB_SATURATE_EN
//                 defined   -> overflowing channels clamp to max/min
//                 undefined -> overflowing channels wrap (low DATA_WIDTH bits)
// Revision    : 1.0 - initial release
// ============================================================================
module real_sub_pipe #(
    parameter int DATA_WIDTH = 22,
    parameter int NUM_CH     = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] a_bus,
    input  logic [NUM_CH*DATA_WIDTH-1:0] b_bus,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] diff_bus,
    output logic [NUM_CH-1:0]            ovf,
    input  logic                         clear_ovf,
    output logic [CNT_WIDTH-1:0]         ovf_count
);

    // Stage 1: captured operands
    logic                         s1_valid_q;
    logic [NUM_CH*DATA_WIDTH-1:0] a_q;
    logic [NUM_CH*DATA_WIDTH-1:0] b_q;

    // Stage 2: registered result
    logic                         s2_valid_q;
    logic [NUM_CH*DATA_WIDTH-1:0] diff_q;
    logic [NUM_CH-1:0]            ovf_q;
    logic [CNT_WIDTH-1:0]         ovf_count_q;

    // Next-state values of stage 2 computed from stage 1
    logic [NUM_CH*DATA_WIDTH-1:0] diff_d;
    logic [NUM_CH-1:0]            ovf_d;

    // Handshake helpers
    logic s2_load;   // S2 may take a new value (empty or draining this cycle)
    logic s1_load;   // S1 may take a new value (empty or advancing into S2)
    logic out_xfer;

    assign out_xfer = s2_valid_q && out_ready;
    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = !rst && s1_load;

    assign out_valid = s2_valid_q;
    assign diff_bus  = diff_q;
    assign ovf       = ovf_q;
    assign ovf_count = ovf_count_q;

`ifdef REAL_SUB_SATURATE_EN
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

    // Per-channel subtraction in DATA_WIDTH+1 bits: the result is exact, so
    // overflow is simply the top two bits disagreeing.
    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic [DATA_WIDTH:0] full;

            assign full = {a_q[c*DATA_WIDTH+DATA_WIDTH-1], a_q[c*DATA_WIDTH +: DATA_WIDTH]}
                        - {b_q[c*DATA_WIDTH+DATA_WIDTH-1], b_q[c*DATA_WIDTH +: DATA_WIDTH]};
            assign ovf_d[c] = full[DATA_WIDTH] ^ full[DATA_WIDTH-1];

`ifdef REAL_SUB_SATURATE_EN
            // Sign of the exact result picks the clamp direction.
            assign diff_d[c*DATA_WIDTH +: DATA_WIDTH] =
                ovf_d[c] ? (full[DATA_WIDTH] ? SAT_MIN : SAT_MAX)
                         : full[DATA_WIDTH-1:0];
`else
            assign diff_d[c*DATA_WIDTH +: DATA_WIDTH] = full[DATA_WIDTH-1:0];
`endif
        end
    endgenerate

    // Stage 1: accept an operand beat whenever the stage is free to refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                a_q <= a_bus;
                b_q <= b_bus;
            end
        end
    end

    // Stage 2: load the result when free or draining; hold steady under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            ovf_q      <= '0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                diff_q <= diff_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    // Overflow event counter: clear has priority, increments saturate.
    always_ff @(posedge clk) begin
        if (rst || clear_ovf) begin
            ovf_count_q <= '0;
        end else if (out_xfer && (|ovf_q) && (ovf_count_q != {CNT_WIDTH{1'b1}})) begin
            ovf_count_q <= ovf_count_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_real_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_real_sub_pipe
// Description : Directed self-checking bench for real_sub_pipe
//               (DATA_WIDTH=8, NUM_CH=2). Honours REAL_SUB_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_real_sub_pipe;

    localparam int DW = 8;
    localparam int NC = 2;
    localparam int CW = 16;

`ifdef REAL_SUB_SATURATE_EN
    localparam logic [7:0] NEG_OVF_RES = 8'h80;
    localparam logic [7:0] POS_OVF_RES = 8'h7F;
`else
    localparam logic [7:0] NEG_OVF_RES = 8'h7F;
    localparam logic [7:0] POS_OVF_RES = 8'h80;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [NC*DW-1:0] a_bus;
    logic [NC*DW-1:0] b_bus;
    logic             out_valid;
    logic             out_ready;
    logic [NC*DW-1:0] diff_bus;
    logic [NC-1:0]    ovf;
    logic             clear_ovf;
    logic [CW-1:0]    ovf_count;

    int n_chk = 0;
    int n_bad = 0;
    int sent;
    int got;
    int stale;

    real_sub_pipe #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NC),
        .CNT_WIDTH  (CW)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff_bus  (diff_bus),
        .ovf       (ovf),
        .clear_ovf (clear_ovf),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_chk++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got_v, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Backpressure beat i: ch0 = 10i - i = 9i, ch1 = i - 2i = -i
    function automatic logic [15:0] bp_a(input int i);
        logic [7:0] x0, x1;
        x0 = 8'(10 * i);
        x1 = 8'(i);
        return {x1, x0};
    endfunction
    function automatic logic [15:0] bp_b(input int i);
        logic [7:0] y0, y1;
        y0 = 8'(i);
        y1 = 8'(2 * i);
        return {y1, y0};
    endfunction
    function automatic logic [15:0] bp_exp(input int i);
        logic [7:0] d0, d1;
        d0 = 8'(9 * i);
        d1 = 8'(0 - i);
        return {d1, d0};
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clear_ovf = 1'b0;
        a_bus     = '0;
        b_bus     = '0;

        // ---- reset state ----
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff",      32'(diff_bus),  32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        check("rst_count",     32'(ovf_count), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // ---- basic: 5-3=2, -4-(-10)=6 ----
        a_bus = {8'hFC, 8'h05};
        b_bus = {8'hF6, 8'h03};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("basic_lat1_valid", 32'(out_valid), 32'd0);
        step();
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_diff",  32'(diff_bus),  32'h0602);
        check("basic_ovf",   32'(ovf),       32'd0);
        step();
        check("basic_drain", 32'(out_valid), 32'd0);

        // ---- negative overflow: -128 - 1 on ch0 ----
        a_bus = {8'h00, 8'h80};
        b_bus = {8'h00, 8'h01};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("neg_diff",      32'(diff_bus),  32'({8'h00, NEG_OVF_RES}));
        check("neg_ovf",       32'(ovf),       32'b01);
        check("neg_count_pre", 32'(ovf_count), 32'd0);
        step();
        check("neg_count", 32'(ovf_count), 32'd1);

        // ---- positive overflow: 127 - (-1) on ch1 ----
        a_bus = {8'h7F, 8'h00};
        b_bus = {8'hFF, 8'h00};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("pos_diff", 32'(diff_bus), 32'({POS_OVF_RES, 8'h00}));
        check("pos_ovf",  32'(ovf),      32'b10);
        step();
        check("pos_count", 32'(ovf_count), 32'd2);

        // ---- backpressure: 6 beats, output stalled for the first 5 cycles ----
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            out_ready = (cyc >= 5);
            in_valid  = (sent < 6);
            a_bus     = bp_a(sent);
            b_bus     = bp_b(sent);
            #1;
            if (cyc == 2) check("bp_in_ready_low", 32'(in_ready), 32'd0);
            if (cyc >= 2 && cyc <= 4) begin
                check("bp_hold_valid", 32'(out_valid), 32'd1);
                check("bp_hold_diff",  32'(diff_bus),  32'(bp_exp(0)));
            end
            if (out_valid && out_ready) begin
                check("bp_order_diff", 32'(diff_bus), 32'(bp_exp(got)));
                check("bp_order_ovf",  32'(ovf),      32'd0);
                got++;
            end
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_sent", 32'(sent), 32'd6);
        check("bp_got",  32'(got),  32'd6);
        step();
        check("bp_empty", 32'(out_valid), 32'd0);

        // ---- counter saturation and clear priority ----
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("clr_count", 32'(ovf_count), 32'd0);
        a_bus = {8'h00, 8'h80};
        b_bus = {8'h00, 8'h01};
        in_valid = 1'b1;
        repeat (65536) step();
        in_valid = 1'b0;
        repeat (3) step();
        check("sat_count", 32'(ovf_count), 32'hFFFF);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("clr_xfer_valid", 32'(out_valid), 32'd1);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("clr_wins", 32'(ovf_count), 32'd0);

        // ---- reset mid-stream with two beats in flight ----
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("pre_rst_count", 32'(ovf_count), 32'd1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        step();
        step();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        check("mid_rst_valid",    32'(out_valid), 32'd0);
        check("mid_rst_count",    32'(ovf_count), 32'd0);
        check("mid_rst_ovf",      32'(ovf),       32'd0);
        check("mid_rst_in_ready", 32'(in_ready),  32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mid_rst_release_ready", 32'(in_ready), 32'd1);
        stale = 0;
        repeat (6) begin
            step();
            if (out_valid) stale++;
        end
        check("no_stale_beat", 32'(stale), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
